// File: rtl/mult32_seq_pkg.sv
// Shared types and helpers for the sequential 32x32 multiplier.
// Holds the FSM encoding, the iteration bound and operand negation.
package mult32_seq_pkg;

    localparam int         MULT_WIDTH     = 32;
    localparam logic [4:0] MULT_ITER_LAST = 5'd31;

    typedef enum logic [2:0] {
        MULT_ST_IDLE   = 3'd0,
        MULT_ST_ITER   = 3'd1,
        MULT_ST_FIX_LO = 3'd2,
        MULT_ST_FIX_HI = 3'd3,
        MULT_ST_DONE   = 3'd4
    } mult_st_e;

    function automatic logic [31:0] twoscomp32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic sgn,
                                          input logic [31:0] v);
        return (sgn & v[31]) ? twoscomp32(v) : v;
    endfunction

endpackage

// File: rtl/mult32_seq_add.sv
// 32-bit ripple-carry adder shared by every datapath step of mult32_seq.
// One full-adder cell per bit, carry rippling from bit 0 upwards.
module mult32_seq_add (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    // Ripple the carry through 32 full-adder cells.
    always_comb begin
        logic c;
        c = i_cin;
        o_sum = '0;
        for (int i = 0; i < 32; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c;
            c = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
        end
        o_cout = c;
    end

endmodule

// File: rtl/mult32_seq.sv
// Multi-cycle 32x32 signed/unsigned multiplier, 64-bit HI/LO result.
// Shift-add on magnitudes, then a two-step sign fix-up on one adder.
module mult32_seq
    import mult32_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    mult_st_e    r_state;
    mult_st_e    w_state_nxt;
    logic [63:0] r_p;
    logic [31:0] r_mcnd;
    logic [4:0]  r_cnt;
    logic        r_c;
    logic        r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic [31:0] w_sum;
    logic        w_cout;

    mult32_seq_add u_add (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next-state logic; fix-up states are always visited.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MULT_ST_IDLE:   if (START) w_state_nxt = MULT_ST_ITER;
            MULT_ST_ITER:   if (r_cnt == MULT_ITER_LAST)
                                w_state_nxt = MULT_ST_FIX_LO;
            MULT_ST_FIX_LO: w_state_nxt = MULT_ST_FIX_HI;
            MULT_ST_FIX_HI: w_state_nxt = MULT_ST_DONE;
            MULT_ST_DONE:   w_state_nxt = MULT_ST_IDLE;
            default:        w_state_nxt = MULT_ST_IDLE;
        endcase
    end

    // Adder operand steering: accumulate, then negate low and high halves.
    always_comb begin
        w_add_a = r_p[63:32];
        w_add_b = '0;
        unique case (r_state)
            MULT_ST_ITER: begin
                w_add_a = r_p[63:32];
                w_add_b = r_p[0] ? r_mcnd : 32'd0;
            end
            MULT_ST_FIX_LO: begin
                w_add_a = ~r_p[31:0];
                w_add_b = 32'd1;
            end
            MULT_ST_FIX_HI: begin
                w_add_a = ~r_p[63:32];
                w_add_b = {31'd0, r_c};
            end
            default: begin
                w_add_a = r_p[63:32];
                w_add_b = '0;
            end
        endcase
    end

    // State and registered status flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= MULT_ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == MULT_ST_ITER)
                     | (w_state_nxt == MULT_ST_FIX_LO)
                     | (w_state_nxt == MULT_ST_FIX_HI);
            r_done  <= (w_state_nxt == MULT_ST_DONE);
        end
    end

    // Datapath registers: load, shift-add, sign fix-up, result capture.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p    <= '0;
            r_mcnd <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_neg  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            unique case (r_state)
                MULT_ST_IDLE: begin
                    if (START) begin
                        r_mcnd <= mag32(SIGNED, A[31:0]);
                        r_p    <= {32'd0, mag32(SIGNED, B[31:0])};
                        r_neg  <= SIGNED & (A[31] ^ B[31]);
                        r_cnt  <= '0;
                        r_c    <= 1'b0;
                    end
                end
                MULT_ST_ITER: begin
                    r_p   <= {w_cout, w_sum, r_p[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                MULT_ST_FIX_LO: begin
                    if (r_neg) begin
                        r_p[31:0] <= w_sum;
                        r_c       <= w_cout;
                    end else begin
                        r_c <= 1'b0;
                    end
                end
                MULT_ST_FIX_HI: begin
                    r_lo <= r_p[31:0];
                    if (r_neg) begin
                        r_p[63:32] <= w_sum;
                        r_hi       <= w_sum;
                    end else begin
                        r_hi <= r_p[63:32];
                    end
                end
                default: begin
                    r_p <= r_p;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed corners plus random
// operands compared with a 64-bit arithmetic reference product.
module tb_mult32_seq;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        SIGNED;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_vec;
    int          n_err;
    logic [63:0] prev;

    mult32_seq #(.WIDTH(32)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SIGNED (SIGNED),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full operation with per-cycle handshake checks. pulse_at injects a
    // stray START mid-operation; done_poke drives START during DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int pulse_at,
                          input bit done_poke, input string tag);
        logic [63:0] exp;
        exp = model(a, b, s);
        @(negedge CLK);
        A = a; B = b; SIGNED = s; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 0; k < 34; k++) begin
            chk({tag, "_busy"}, 64'(BUSY), 64'd1);
            chk({tag, "_nodone"}, 64'(DONE), 64'd0);
            chk({tag, "_hold"}, {HI, LO}, prev);
            if (k == pulse_at) begin
                START = 1'b1; A = 32'h9; B = 32'h9; SIGNED = 1'b0;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
        end
        chk({tag, "_done"}, 64'(DONE), 64'd1);
        chk({tag, "_busy_lo"}, 64'(BUSY), 64'd0);
        chk({tag, "_res"}, {HI, LO}, exp);
        if (done_poke) START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk({tag, "_done_end"}, 64'(DONE), 64'd0);
        chk({tag, "_idle"}, 64'(BUSY), 64'd0);
        if (done_poke) begin
            @(posedge CLK); #1;
            chk({tag, "_poke_ign"}, 64'(BUSY), 64'd0);
        end
        prev = exp;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] hexp;
        int          pulses;
        int          last_t;
        CLK = 1'b0; RST = 1'b0; START = 1'b0; SIGNED = 1'b0;
        A = '0; B = '0;
        n_vec = 0; n_err = 0; prev = '0;

        #12;
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 1'b0, "uff");
        chk("uff_const", prev, 64'hFFFFFFFE_00000001);
        run_op(32'hFFFFFFFF, 32'h5, 1'b1, -1, 1'b1, "sm1x5");
        chk("sm1x5_const", prev, 64'hFFFFFFFF_FFFFFFFB);
        run_op(32'hFFFFFFFF, 32'h5, 1'b0, -1, 1'b0, "um1x5");
        chk("um1x5_const", prev, 64'h00000004_FFFFFFFB);
        run_op(32'h80000000, 32'h80000000, 1'b1, -1, 1'b0, "smin2");
        chk("smin2_const", prev, 64'h40000000_00000000);
        run_op(32'h80000000, 32'h1, 1'b1, -1, 1'b0, "sminx1");
        chk("sminx1_const", prev, 64'hFFFFFFFF_80000000);
        run_op(32'h3, 32'h7, 1'b0, 5, 1'b0, "ignore");
        chk("ignore_const", prev, 64'h15);

        // Abort at iteration 10 with an asynchronous reset.
        @(negedge CLK);
        A = 32'h1234; B = 32'h4321; SIGNED = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_done", 64'(DONE), 64'd0);
        chk("arst_hilo", {HI, LO}, 64'd0);
        prev = '0;
        @(negedge CLK);
        RST = 1'b1;
        run_op(32'h10000, 32'h10000, 1'b0, -1, 1'b0, "post_rst");
        chk("post_rst_const", prev, 64'h00000001_00000000);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 6 == 0) ra = 32'h80000000;
            if (i % 6 == 1) rb = 32'h0;
            if (i % 6 == 2) rb = 32'hFFFFFFFF;
            run_op(ra, rb, rs, -1, 1'b0, "rnd");
        end

        // START held high: one DONE pulse every 36 cycles, stable result.
        hexp = model(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        @(negedge CLK);
        A = 32'hDEADBEEF; B = 32'hCAFEF00D; SIGNED = 1'b1; START = 1'b1;
        pulses = 0;
        last_t = 0;
        for (int t = 1; t <= 200 && pulses < 4; t++) begin
            @(posedge CLK); #1;
            chk("held_excl", 64'(BUSY & DONE), 64'd0);
            if (DONE) begin
                if (pulses > 0) chk("held_period", 64'(t - last_t), 64'd36);
                chk("held_res", {HI, LO}, hexp);
                pulses++;
                last_t = t;
            end else if (pulses > 0) begin
                chk("held_stable", {HI, LO}, hexp);
            end
        end
        chk("held_pulses", 64'(pulses), 64'd4);
        START = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Multi-cycle 32x32 multiplier controller that produces the same 64-bit HI/LO result as the combinational multiplier, using one shared 32-bit ripple-carry adder over 34 cycles. It sits beside the ALU as a low-area MUL path for the processor control unit. It supports signed and unsigned operands with a start/busy/done handshake. The FSM sequences the shift-add iterations and the final two's-complement fix-up through that single adder.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; latched with START.
- A  input  32  multiplicand; latched with START.
- B  input  32  multiplier; latched with START.
- BUSY  output  1  high in ITER, FIX_LO, FIX_HI.
- DONE  output  1  one-cycle pulse in the DONE state.
- HI  output  32  upper product word; registered.
- LO  output  32  lower product word; registered.

## Operation
- States: IDLE, ITER, FIX_LO, FIX_HI, DONE.
- IDLE with START=1: latch the operands and go to ITER.
  - mcnd = (SIGNED & A[31]) ? -A : A.
  - P[63:0] = {32'b0, |B| under the same rule}.
  - neg = SIGNED & (A[31] ^ B[31]).
  - Clear the 5-bit counter cnt.
- ITER, each cycle:
  - Adder computes sum/cout = P[63:32] + (P[0] ? mcnd : 0), carry-in 0.
  - P <= {cout, sum, P[31:1]}.
  - cnt increments; on cnt==31, go to FIX_LO.
- FIX_LO: if neg, P[31:0] <= ~P[31:0] + 1 via the adder, and its carry-out is saved in a 1-bit reg c. Otherwise P is held and c=0. Always go to FIX_HI.
- FIX_HI: if neg, P[63:32] <= ~P[63:32] + c via the adder. Otherwise P is held. HI/LO are loaded from the final P. Go to DONE.
- DONE: DONE=1 for one cycle, then go to IDLE.
- The fix-up states are always traversed, so latency does not depend on the data.
- START outside IDLE is ignored, including in DONE. Operands and SIGNED are not re-sampled during an operation.
- HI/LO keep the previous result during an operation and change only at the FIX_HI->DONE edge.
- Magnitude of 0x80000000 is 0x80000000 as an unsigned value, which is correct; no overflow case exists.
- Reset, including mid-operation: state=IDLE; P, cnt, c, neg, HI, LO = 0; BUSY=0; DONE=0, all immediately (async). The operation is abandoned.

## Timing
- START accepted at edge N.
- ITER occupies edges N+1..N+32.
- FIX_LO at N+33, FIX_HI at N+34; HI/LO valid after N+34.
- DONE=1 in the cycle between N+34 and N+35; IDLE after N+35.
- Earliest next accept is at edge N+36, so back-to-back throughput is one result per 36 cycles.
- BUSY=1 from after N to after N+34; BUSY and DONE are never high together.
- All outputs come directly from registers.

## Structure
- Add to prj_definition.v:
  - State encodings `MULT_ST_IDLE`, `MULT_ST_ITER`, `MULT_ST_FIX_LO`, `MULT_ST_FIX_HI`, `MULT_ST_DONE` (3-bit).
  - `MULT_ITER_LAST` (31).
- One sub-module instance: RC_ADD_SUB_32 as the shared adder.
  - Operand muxing (P-high/mcnd, ~P-low/1, ~P-high/c) is done by MUX32_2x1 instances or equivalent in this block.
  - Negation at load uses the existing TWOSCOMP32.
- The FSM and data registers live in this block; no further sub-modules.

## Test plan
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DONE exactly one cycle, in the cycle after edge N+34.
- Signed 0xFFFFFFFF (-1) x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFFB. Same operands unsigned -> HI=0x00000004, LO=0xFFFFFFFB.
- Signed 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0. Signed 0x80000000 x 0x00000001 -> HI=0xFFFFFFFF, LO=0x80000000.
- Issue 0x3 x 0x7, then pulse START with 0x9 x 0x9 during ITER -> result HI=0, LO=0x15. The second request is ignored and BUSY stays high throughout.
- RST low at iteration 10 -> BUSY, DONE, HI, LO = 0 immediately. After release, START 0x10000 x 0x10000 -> HI=0x1, LO=0 with full 34-cycle latency.
- START held high with fixed operands -> DONE pulses every 36 cycles. HI/LO stable between pulses.
